// File: rtl/soc_mem_io.sv
// soc_mem_io
//   Memory and I/O slave on the processor's native memory port. Holds program
//   and data RAM (word-addressed, wraps modulo RAM size) and a small
//   memory-mapped I/O page with an LED register and an 8N1 UART transmitter.
//   Read data is registered with one cycle of latency and holds between strobes.
//
//   I/O map (mem_addr[22] = 1, register chosen by mem_addr[4:2]):
//     0x0040_0004  LEDS        read/write, lane 0 only
//     0x0040_0008  UART_DATA   write only (reads 0)
//     0x0040_0010  UART_STATUS read only: bit 9 tx_full, bit 8 tx_active
//
//   Build option: define SOC_UART_FIFO_EN to place a 4-entry TX FIFO between
//   UART_DATA and the transmitter; otherwise a write is accepted only while the
//   transmitter is idle.
//
// Ports:
//   clk        rising-edge clock
//   resetn     synchronous active-low reset
//   mem_addr   byte address
//   mem_rdata  registered read data
//   mem_rstrb  read strobe
//   mem_wdata  write data (byte-lane replicated)
//   mem_wmask  byte write enables, nonzero means write
//   leds       LED register
//   uart_tx    serial output, idle high
module soc_mem_io #(
  parameter int    RAM_WORDS   = 2048,
  parameter string INIT_FILE   = "firmware.hex",
  parameter int    LED_W       = 5,
  parameter int    CLK_FREQ_HZ = 50000000,
  parameter int    BAUD        = 115200
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      mem_addr,
  output logic [31:0]      mem_rdata,
  input  logic             mem_rstrb,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wmask,
  output logic [LED_W-1:0] leds,
  output logic             uart_tx
);

  localparam int AW  = $clog2(RAM_WORDS);
  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int CW  = $clog2(DIV);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic          is_io;
  logic          wr;
  logic          sel_leds;
  logic          sel_udata;
  logic          sel_status;
  logic [AW-1:0] ram_idx;

  assign is_io      = mem_addr[22];
  assign wr         = |mem_wmask;
  assign ram_idx    = mem_addr[AW+1:2];
  assign sel_leds   = is_io && (mem_addr[4:2] == 3'b001);
  assign sel_udata  = is_io && (mem_addr[4:2] == 3'b010);
  assign sel_status = is_io && (mem_addr[4:2] == 3'b100);

  logic unused_addr;
  assign unused_addr = ^{mem_addr[31:23], mem_addr[21:AW+2], mem_addr[1:0]};

  // ---------------------------------------------------------------------------
  // RAM (contents survive reset)
  // ---------------------------------------------------------------------------
  logic [31:0] ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (wr && !is_io) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (mem_wmask[i]) ram[ram_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // UART status / queue signals
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  tx_state_t state, state_n;
  logic      tx_active;
  logic      tx_full;
  logic      push_req;
  logic      q_valid;
  logic [7:0] q_head;
  logic      avail;
  logic [7:0] next_byte;
  logic      last;

  assign tx_active = (state != IDLE);
  assign push_req  = sel_udata && mem_wmask[0] && !tx_full;

  // A byte written while the transmitter is ready is handed straight to it,
  // so the start bit appears the cycle after the write.
  assign avail     = q_valid || push_req;
  assign next_byte = q_valid ? q_head : mem_wdata[7:0];

`ifdef SOC_UART_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] fifo_cnt;
  logic       take;
  logic       push;
  logic       pop;

  assign q_valid = (fifo_cnt != 3'd0);
  assign q_head  = fifo_mem[rd_ptr];
  assign tx_full = (fifo_cnt == 3'd4);
  assign take    = (state == IDLE) || ((state == STOP) && last);
  assign pop     = take && q_valid;
  // Bypass: an empty FIFO with the transmitter ready consumes the write directly.
  assign push    = push_req && !(take && !q_valid);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end
`else
  // Holding register collapses to the transmitter itself: writes are only
  // accepted when idle and start the frame immediately.
  assign q_valid = 1'b0;
  assign q_head  = '0;
  assign tx_full = tx_active;
`endif

  // ---------------------------------------------------------------------------
  // UART transmitter FSM
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    sh, sh_n;
  logic [2:0]    bitc, bitc_n;
  logic          tx_n;

  assign last = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      sh      <= '0;
      bitc    <= '0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sh      <= sh_n;
      bitc    <= bitc_n;
      uart_tx <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    sh_n    = sh;
    bitc_n  = bitc;
    tx_n    = uart_tx;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (avail) begin
          state_n = START;
          sh_n    = next_byte;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (last) begin
          cnt_n   = '0;
          state_n = DATA;
          bitc_n  = '0;
          tx_n    = sh[0];
          sh_n    = {1'b0, sh[7:1]};
        end
      end
      DATA: begin
        if (last) begin
          cnt_n = '0;
          if (bitc == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bitc_n = bitc + 3'd1;
            tx_n   = sh[0];
            sh_n   = {1'b0, sh[7:1]};
          end
        end
      end
      STOP: begin
        if (last) begin
          cnt_n = '0;
          if (avail) begin
            state_n = START;
            sh_n    = next_byte;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // LEDs and read data
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      leds <= '0;
    end else if (sel_leds && mem_wmask[0]) begin
      leds <= mem_wdata[LED_W-1:0];
    end
  end

  logic [31:0] io_rdata;

  always_comb begin
    io_rdata = '0;
    if (sel_leds)   io_rdata = 32'(leds);
    if (sel_status) io_rdata = {22'd0, tx_full, tx_active, 8'd0};
  end

  // Old RAM word is returned when a write hits the same word in the strobe cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_rdata <= '0;
    end else if (mem_rstrb) begin
      mem_rdata <= is_io ? io_rdata : ram[ram_idx];
    end
  end

endmodule
